// File: rtl/mc_pkg.sv
// mc_pkg: shared encodings for the multicycle control sequencer.
//   - FSM state encodings (also exported on the State debug port)
//   - opcode / funct constants for the supported MIPS subset
//   - datapath mux select encodings (RegDst, MemtoReg, ALUSrcB, PCSource)
//   - op_class_t: one-hot instruction class produced by mc_op_class
package mc_pkg;

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_MULWAIT = 3'd5
    } state_e;

    localparam logic [5:0] OP_RTYPE    = 6'b000000;
    localparam logic [5:0] OP_J        = 6'b000010;
    localparam logic [5:0] OP_JAL      = 6'b000011;
    localparam logic [5:0] OP_BEQ      = 6'b000100;
    localparam logic [5:0] OP_BNE      = 6'b000101;
    localparam logic [5:0] OP_MUL      = 6'b011100;
    localparam logic [5:0] OP_SPECIAL3 = 6'b011111;
    localparam logic [5:0] OP_LB       = 6'b100000;
    localparam logic [5:0] OP_LH       = 6'b100001;
    localparam logic [5:0] OP_LW       = 6'b100011;
    localparam logic [5:0] OP_SB       = 6'b101000;
    localparam logic [5:0] OP_SH       = 6'b101001;
    localparam logic [5:0] OP_SW       = 6'b101011;

    localparam logic [5:0] FUNCT_JR    = 6'b001000;

    localparam logic [1:0] RD_RT      = 2'b00;
    localparam logic [1:0] RD_RD      = 2'b01;
    localparam logic [1:0] RD_RA      = 2'b10;

    localparam logic [1:0] M2R_ALU    = 2'b00;
    localparam logic [1:0] M2R_MDR    = 2'b01;
    localparam logic [1:0] M2R_PC     = 2'b10;

    localparam logic [1:0] ASB_RT     = 2'b00;
    localparam logic [1:0] ASB_FOUR   = 2'b01;
    localparam logic [1:0] ASB_IMM    = 2'b10;
    localparam logic [1:0] ASB_IMM_SH = 2'b11;

    localparam logic [1:0] PCS_ALU    = 2'b00;
    localparam logic [1:0] PCS_ALUOUT = 2'b01;
    localparam logic [1:0] PCS_JUMP   = 2'b10;
    localparam logic [1:0] PCS_RS     = 2'b11;

    typedef struct packed {
        logic rtype;
        logic jr;
        logic imm;
        logic load;
        logic store;
        logic branch;
        logic jump;
        logic jal;
        logic mul;
        logic illegal;
    } op_class_t;

endpackage

// File: rtl/mc_ctrl_fsm_op_class.sv
// mc_op_class: combinational instruction classifier.
//   opcode   in  6   IR[31:26]
//   funct    in  6   IR[5:0], only consulted for opcode 000000 (jr detect)
//   op_class out     one-hot class; exactly one bit is set for any input
module mc_op_class
    import mc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    output op_class_t  op_class
);

    always_comb begin
        op_class = '0;
        casez (opcode)
            OP_RTYPE: begin
                if (funct == FUNCT_JR) op_class.jr = 1'b1;
                else                   op_class.rtype = 1'b1;
            end
            6'b000001, 6'b0001??:     op_class.branch  = 1'b1;
            OP_J:                     op_class.jump    = 1'b1;
            OP_JAL:                   op_class.jal     = 1'b1;
            6'b001???:                op_class.imm     = 1'b1;
            OP_SPECIAL3:              op_class.rtype   = 1'b1;
            OP_MUL:                   op_class.mul     = 1'b1;
            OP_LB, OP_LH, OP_LW:      op_class.load    = 1'b1;
            OP_SB, OP_SH, OP_SW:      op_class.store   = 1'b1;
            default:                  op_class.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// mc_ctrl_fsm: multicycle control sequencer for the MIPS-subset datapath.
// Steps each instruction through FETCH/DECODE/EXEC/MEM/WB, sharing one memory
// port (MemReq held until MemAck) and stalling in MULWAIT for the multiplier.
//
// Ports:
//   Clk, Rst_n                 clock (rising edge), async active-low reset
//   Opcode, Funct, MemAck      instruction fields, memory completion
//   PCWrite, PCWriteCond       PC load (unconditional / branch-gated)
//   IRWrite, IorD              IR latch, memory address select
//   MemReq, MemWrite           memory request / store qualifier
//   RegWrite, RegDst, MemtoReg register file write controls
//   ALUSrcA, ALUSrcB, ALUOp    ALU operand selects and operation
//   PCSource                   next-PC select
//   IllegalOp                  one-cycle pulse on unsupported opcode
//   State                      current state, debug
//
// state   | meaning
// --------+-----------------------------------------------------------
// FETCH   | read instruction at PC, PC <= PC+4 on ack
// DECODE  | classify opcode, precompute branch target into ALUOut
// EXEC    | ALU op / branch / jump / mul start, by instruction class
// MEM     | data access at ALUOut, held until ack
// WB      | register file write
// MULWAIT | hold multiply operands until the result is valid
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int unsigned MUL_LAT   = 4,
    parameter logic [5:0]  ADD_ALUOP = 6'b001000
) (
    input  logic       Clk,
    input  logic       Rst_n,
    input  logic [5:0] Opcode,
    input  logic [5:0] Funct,
    input  logic       MemAck,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IRWrite,
    output logic       IorD,
    output logic       MemReq,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic [1:0] RegDst,
    output logic [1:0] MemtoReg,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [5:0] ALUOp,
    output logic       IllegalOp,
    output logic [2:0] State
);

    state_e    state_q, state_d;
    logic [3:0] mul_cnt_q, mul_cnt_d;
    op_class_t cls;

    mc_op_class u_op_class (
        .opcode   (Opcode),
        .funct    (Funct),
        .op_class (cls)
    );

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q   <= S_FETCH;
            mul_cnt_q <= 4'd0;
        end else begin
            state_q   <= state_d;
            mul_cnt_q <= mul_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mul_cnt_d   = mul_cnt_q;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IRWrite     = 1'b0;
        IorD        = 1'b0;
        MemReq      = 1'b0;
        MemWrite    = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = RD_RT;
        MemtoReg    = M2R_ALU;
        ALUSrcA     = 1'b0;
        ALUSrcB     = ASB_RT;
        PCSource    = PCS_ALU;
        ALUOp       = 6'd0;
        IllegalOp   = 1'b0;

        case (state_q)
            S_FETCH: begin
                MemReq  = 1'b1;
                ALUSrcB = ASB_FOUR;
                ALUOp   = ADD_ALUOP;
                if (MemAck) begin
                    IRWrite = 1'b1;
                    PCWrite = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = ASB_IMM_SH;
                ALUOp   = ADD_ALUOP;
                if (cls.illegal) begin
                    IllegalOp = 1'b1;
                    state_d   = S_FETCH;
                end else begin
                    state_d   = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_FETCH;
                if (cls.rtype) begin
                    ALUSrcA = 1'b1;
                    ALUOp   = Opcode;
                    state_d = S_WB;
                end else if (cls.jr) begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_RS;
                end else if (cls.imm) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ASB_IMM;
                    ALUOp   = Opcode;
                    state_d = S_WB;
                end else if (cls.load || cls.store) begin
                    ALUSrcA = 1'b1;
                    ALUSrcB = ASB_IMM;
                    ALUOp   = ADD_ALUOP;
                    state_d = S_MEM;
                end else if (cls.branch) begin
                    ALUSrcA     = 1'b1;
                    ALUOp       = Opcode;
                    PCWriteCond = 1'b1;
                    PCSource    = PCS_ALUOUT;
                end else if (cls.jump || cls.jal) begin
                    PCWrite  = 1'b1;
                    PCSource = PCS_JUMP;
                    if (cls.jal) begin
                        RegWrite = 1'b1;
                        RegDst   = RD_RA;
                        MemtoReg = M2R_PC;
                    end
                end else if (cls.mul) begin
                    ALUSrcA   = 1'b1;
                    ALUOp     = Opcode;
                    mul_cnt_d = 4'(MUL_LAT - 1);
                    state_d   = (MUL_LAT == 1) ? S_WB : S_MULWAIT;
                end
            end
            S_MULWAIT: begin
                ALUSrcA = 1'b1;
                ALUOp   = Opcode;
                // Counter holds the cycles still owed; the value 1 marks the last one.
                if (mul_cnt_q <= 4'd1) begin
                    mul_cnt_d = 4'd0;
                    state_d   = S_WB;
                end else begin
                    mul_cnt_d = mul_cnt_q - 4'd1;
                end
            end
            S_MEM: begin
                MemReq   = 1'b1;
                IorD     = 1'b1;
                MemWrite = cls.store;
                if (MemAck) state_d = cls.store ? S_FETCH : S_WB;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (cls.rtype || cls.mul) ? RD_RD : RD_RT;
                MemtoReg = cls.load ? M2R_MDR : M2R_ALU;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase

        // The state register already sits in FETCH while reset is held; masking
        // here keeps FETCH's request off the bus until reset actually releases.
        if (!Rst_n) begin
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IRWrite     = 1'b0;
            IorD        = 1'b0;
            MemReq      = 1'b0;
            MemWrite    = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = RD_RT;
            MemtoReg    = M2R_ALU;
            ALUSrcA     = 1'b0;
            ALUSrcB     = ASB_RT;
            PCSource    = PCS_ALU;
            ALUOp       = 6'd0;
            IllegalOp   = 1'b0;
        end
    end

    assign State = state_q;

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Multicycle control sequencer for the MIPS-subset datapath. It reuses the same 6-bit opcode encoding and 6-bit ALUOp convention as the single-cycle main decoder. Instead of emitting one static control word per opcode, it steps each instruction through FETCH/DECODE/EXEC/MEM/WB over several cycles. It shares one unified memory port between instruction fetch and data access via a req/ack handshake, and stalls on a multi-cycle multiplier.

Parameters:
MUL_LAT, 4, cycles the multiplier needs from EXEC entry to a valid result (legal range 1..15)
ADD_ALUOP, 6'b001000, ALUOp driven for PC+4 and address-add micro-ops

Ports:
Clk  in  1  system clock, rising edge
Rst_n  in  1  asynchronous active-low reset
Opcode  in  6  IR[31:26], valid from DECODE onward
Funct  in  6  IR[5:0]; funct 001000 = jr
MemAck  in  1  memory completes the current request this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load gated by datapath branch compare
IRWrite  out  1  latch fetched word into IR
IorD  out  1  0 = PC addresses memory, 1 = ALUOut addresses memory
MemReq  out  1  memory request, held until MemAck
MemWrite  out  1  qualifies MemReq as a store
RegWrite  out  1  register file write
RegDst  out  2  00 = rt, 01 = rd, 10 = $31
MemtoReg  out  2  00 = ALUOut, 01 = MDR, 10 = PC
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrcB  out  2  00 = rt, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
PCSource  out  2  00 = ALU, 01 = ALUOut, 10 = jump target, 11 = rs
ALUOp  out  6  operation code to ALU control
IllegalOp  out  1  one-cycle pulse on unsupported opcode
State  out  3  current state, for debug

Behaviour:
- States (3-bit encoding): FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, MULWAIT=5.
- Reset: State=FETCH. Mul counter is 0. All outputs deassert, except that FETCH Moore outputs appear as soon as reset releases.
- Outputs are combinational from the state plus Opcode/Funct/MemAck. Every output not listed for a state is 0.
- FETCH:
  - MemReq=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=ADD_ALUOP.
  - Stay in FETCH while MemAck=0.
  - When MemAck=1: IRWrite=1, PCWrite=1, PCSource=00, next state DECODE.
  - Zero-wait memory is allowed: MemAck in the first FETCH cycle gives a 1-cycle FETCH.
- DECODE:
  - ALUSrcA=0, ALUSrcB=11, ALUOp=ADD_ALUOP (precomputes the branch target).
  - Next state is EXEC for every opcode in the supported set: 000000, 000001–000111, 001000–001111, 011100, 011111, 100000, 100001, 100011, 101000, 101001, 101011.
  - Any other opcode: IllegalOp=1 for this cycle, next state FETCH. No register or memory side effects.
- EXEC, by instruction class:
  - R-type, 011111: ALUSrcA=1, ALUSrcB=00, ALUOp=Opcode; next WB.
  - jr (Opcode 000000, Funct 001000): PCWrite=1, PCSource=11; next FETCH.
  - Immediate (001xxx): ALUSrcA=1, ALUSrcB=10, ALUOp=Opcode; next WB.
  - Load/store: ALUSrcA=1, ALUSrcB=10, ALUOp=ADD_ALUOP; next MEM.
  - Branches (000001, 000100–000111): ALUSrcA=1, ALUSrcB=00, ALUOp=Opcode, PCWriteCond=1, PCSource=01; next FETCH.
  - j: PCWrite=1, PCSource=10; next FETCH.
  - jal: same as j, plus RegWrite=1, RegDst=10, MemtoReg=10. The datapath latches PC+4 before the PC update.
  - 011100: ALUSrcA=1, ALUSrcB=00, ALUOp=Opcode. Load the counter with MUL_LAT-1. If MUL_LAT=1, next WB; otherwise next MULWAIT.
- MULWAIT:
  - Hold the EXEC 011100 ALU outputs and decrement the counter.
  - When the counter reaches 1, next WB. Total cycles spent in EXEC plus MULWAIT = MUL_LAT.
- MEM:
  - MemReq=1, IorD=1. MemWrite=1 for 101xxx.
  - Hold MEM until MemAck.
  - On MemAck: a store goes to FETCH; a load goes to WB. The MDR latches on ack.
- WB:
  - RegWrite=1.
  - RegDst=01 for R-type, 011111 and 011100; otherwise 00.
  - MemtoReg=01 for loads; otherwise 00.
  - Next state FETCH.
- Cycle counts with zero-wait memory: R/imm/mul(MUL_LAT=1) = 4, load = 5, store = 4, branch/jump/jr = 3. Each memory wait cycle adds 1.
- MemAck outside FETCH/MEM is ignored. MemReq never drops before MemAck.
- Reset asserted mid-instruction aborts immediately: State=FETCH, counter cleared, no partial write completes.

Decomposition:
- Shared package mc_pkg holds:
  - state encodings;
  - opcode constants: OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_MUL, OP_SPECIAL3, OP_LB/LH/LW, OP_SB/SH/SW;
  - FUNCT_JR;
  - RegDst, MemtoReg, ALUSrcB and PCSource select encodings.
- One sub-module: mc_op_class, a combinational classifier from Opcode/Funct to a one-hot class: rtype, jr, imm, load, store, branch, jump, jal, mul, illegal.

Test Plan:
- lw (100011), MemAck high on the 3rd FETCH cycle and the 2nd MEM cycle: states F,F,F,D,E,M,M,W,F; RegWrite=1 with MemtoReg=01 in exactly one cycle.
- sw (101011) with zero-wait memory: F,D,E,M,F; MemReq=1 with MemWrite=1 in MEM only; RegWrite never asserted.
- mul (011100), MUL_LAT=4: EXEC plus 3 MULWAIT cycles, then WB with RegDst=01, RegWrite=1; 7 cycles total.
- jal (000011): EXEC shows PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10; back in FETCH 3 cycles after FETCH entry.
- Opcode 010000 in DECODE: IllegalOp pulses for 1 cycle, next state FETCH, no RegWrite/MemReq.
- Rst_n low during the 2nd MEM wait cycle of a store: State=0 and MemReq drops within the same cycle; after release, FETCH restarts with MemReq=1.
